// File: rtl/fpu_pkg.sv
// fpu_pkg: issue FSM states, canonical NaN and default opcode map shared by the FPU issue logic.
package fpu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} issue_state_e;
  localparam logic [31:0] FPU_QNAN = 32'h7FC00000;
  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_MUL  = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_SQRT = 2'd3;
endpackage

// File: rtl/fpu_issue_mux.sv
// fpu_issue_mux: selects the result slice and rdy bit of the unit addressed by op.
module fpu_issue_mux #(
  parameter int NUM_UNIT = 4,
  parameter int OP_W     = 2
) (
  input  logic [OP_W-1:0]        op,
  input  logic [NUM_UNIT*32-1:0] result,
  input  logic [NUM_UNIT-1:0]    rdy,
  output logic [31:0]            sel_result,
  output logic                   sel_rdy
);
  always_comb begin
    sel_result = '0;
    sel_rdy    = 1'b0;
    for (int i = 0; i < NUM_UNIT; i++) begin
      if (op == OP_W'(i)) begin
        sel_result = result[32*i +: 32];
        sel_rdy    = rdy[i];
      end
    end
  end
endmodule

// File: rtl/fpu_issue.sv
// fpu_issue: issues one operation at a time to an FPU unit and returns its result.
// Optional watchdog on the unit response: define FPU_ISSUE_TIMEOUT_EN.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int NUM_UNIT    = 4,
  parameter int OP_W        = 2,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [OP_W-1:0]        req_op,
  input  logic [TAG_W-1:0]       req_tag,
  input  logic [31:0]            req_a,
  input  logic [31:0]            req_b,
  output logic [31:0]            fpu_din1,
  output logic [31:0]            fpu_din2,
  output logic [NUM_UNIT-1:0]    fpu_dval,
  input  logic [NUM_UNIT*32-1:0] fpu_result,
  input  logic [NUM_UNIT-1:0]    fpu_rdy,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [TAG_W-1:0]       resp_tag,
  output logic [31:0]            resp_data,
  output logic                   resp_err
);
  issue_state_e state;
  logic [OP_W-1:0] op_q;
  logic [31:0] sel_result;
  logic sel_rdy;
  logic accept;
  logic legal;
  logic timeout;

  assign accept = req_valid && req_ready;
  assign legal  = 32'(req_op) < 32'(NUM_UNIT);

  fpu_issue_mux #(.NUM_UNIT(NUM_UNIT), .OP_W(OP_W)) u_mux (
    .op         (op_q),
    .result     (fpu_result),
    .rdy        (fpu_rdy),
    .sel_result (sel_result),
    .sel_rdy    (sel_rdy)
  );

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1) < 8 ? 8 : $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
  end
  assign timeout = cnt == CNT_W'(TIMEOUT_CYC - 1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      req_ready  <= 1'b0;
      fpu_din1   <= '0;
      fpu_din2   <= '0;
      fpu_dval   <= '0;
      resp_valid <= 1'b0;
      resp_tag   <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= !accept;
          if (accept) begin
            op_q     <= req_op;
            resp_tag <= req_tag;
            fpu_din1 <= req_a;
            fpu_din2 <= req_b;
            if (legal) begin
              fpu_dval <= NUM_UNIT'(1) << req_op;
              state    <= ISSUE;
            end else begin
              resp_data <= FPU_QNAN;
              resp_err  <= 1'b1;
              state     <= RESP;
            end
          end
        end
        ISSUE: begin
          fpu_dval <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (sel_rdy || timeout) begin
            resp_data  <= sel_rdy ? sel_result : FPU_QNAN;
            resp_err   <= !sel_rdy;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        default: begin
          // illegal opcodes enter here with resp_valid still low
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: directed scoreboard bench for fpu_issue with three modelled FPU units.
module tb_fpu_issue;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_ready;
  logic [1:0] req_op;
  logic [3:0] req_tag;
  logic [31:0] req_a, req_b;
  logic [31:0] fpu_din1, fpu_din2;
  logic [2:0] fpu_dval, fpu_rdy;
  logic [95:0] fpu_result;
  logic resp_valid, resp_ready;
  logic [3:0] resp_tag;
  logic [31:0] resp_data;
  logic resp_err;

  logic [31:0] unit_res [3];
  int lat [3];
  int ucnt [3];
  logic stray;
  exp_t sb [$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_issue #(.NUM_UNIT(3), .OP_W(2), .TAG_W(4), .TIMEOUT_CYC(20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .req_a      (req_a),
    .req_b      (req_b),
    .fpu_din1   (fpu_din1),
    .fpu_din2   (fpu_din2),
    .fpu_dval   (fpu_dval),
    .fpu_result (fpu_result),
    .fpu_rdy    (fpu_rdy),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_tag   (resp_tag),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  // Unit model: rdy pulses lat cycles after the cycle dval was seen; lat=0 never answers.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n)            ucnt[i] <= 0;
      else if (fpu_dval[i])  ucnt[i] <= lat[i] - 1;
      else if (ucnt[i] > 0)  ucnt[i] <= ucnt[i] - 1;
    end
  end
  assign fpu_rdy    = {ucnt[2] == 1 || stray, ucnt[1] == 1, ucnt[0] == 1};
  assign fpu_result = {unit_res[2], unit_res[1], unit_res[0]};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    int io = int'(op);
    exp_t e;
    req_op = op; req_tag = tag; req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", 64'(req_ready), 64'(1));
    e.tag  = tag;
    e.err  = !(io < 3 && lat[io] != 0);
    e.data = e.err ? QNAN : unit_res[io];
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("dval_cycle1", 64'(fpu_dval), 64'(io < 3 ? 3'b001 << io : 3'b000));
    check("din1", 64'(fpu_din1), 64'(a));
    check("din2", 64'(fpu_din2), 64'(b));
    check("req_ready_busy", 64'(req_ready), 64'(0));
  endtask

  task automatic wait_resp(input int start, input int exp_cyc, input string tag);
    int c = start;
    exp_t e;
    while (!resp_valid && c < 400) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_latency"}, 64'(c), 64'(exp_cyc));
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_tag"}, 64'(resp_tag), 64'(e.tag));
      check({tag, "_data"}, 64'(resp_data), 64'(e.data));
      check({tag, "_err"}, 64'(resp_err), 64'(e.err));
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_after_hs", 64'(resp_valid), 64'(0));
    check("req_ready_hs_plus1", 64'(req_ready), 64'(0));
    @(negedge clk);
    check("req_ready_hs_plus2", 64'(req_ready), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_tag = '0; req_a = '0; req_b = '0;
    resp_ready = 1'b0; stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      unit_res[i] = '0;
      lat[i] = 4;
    end
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_dval", 64'(fpu_dval), 64'(0));
    check("rst_din1", 64'(fpu_din1), 64'(0));
    check("rst_din2", 64'(fpu_din2), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_tag", 64'(resp_tag), 64'(0));
    check("rst_resp_data", 64'(resp_data), 64'(0));
    check("rst_resp_err", 64'(resp_err), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_rst", 64'(req_ready), 64'(1));

    // multiply, unit latency 12: response in cycle 13
    unit_res[1] = 32'h40C00000; lat[1] = 12;
    issue(2'd1, 4'd5, 32'h40000000, 32'h40400000);
    @(negedge clk);
    check("mul_dval_cycle2", 64'(fpu_dval), 64'(0));
    wait_resp(2, 13, "mul");
    handshake();

    // backpressure: response held for 10 cycles
    unit_res[0] = 32'h41200000; lat[0] = 3;
    issue(2'd0, 4'd9, 32'h41000000, 32'h3F800000);
    wait_resp(1, 4, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(resp_valid), 64'(1));
      check("bp_data_held", 64'(resp_data), 64'(32'h41200000));
      check("bp_tag_held", 64'(resp_tag), 64'(9));
      check("bp_req_ready", 64'(req_ready), 64'(0));
    end
    handshake();

    // illegal opcode: no dval, error response two cycles after accept
    issue(2'd3, 4'hA, 32'h1, 32'h2);
    wait_resp(1, 2, "illegal");
    handshake();

    // stray rdy from unit 2 while waiting on unit 0
    unit_res[0] = 32'h3F800000; unit_res[2] = 32'hDEADBEEF; lat[0] = 6;
    issue(2'd0, 4'd3, 32'h3F800000, 32'h00000000);
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    wait_resp(3, 7, "stray");
    handshake();

    // reset during WAIT abandons the operation
    lat[1] = 12;
    issue(2'd1, 4'd7, 32'h40000000, 32'h40000000);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check("rst_wait_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_wait_req_ready", 64'(req_ready), 64'(0));
    check("rst_wait_dval", 64'(fpu_dval), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_wait_req_ready_rel", 64'(req_ready), 64'(1));
    check("rst_wait_no_resp", 64'(resp_valid), 64'(0));
    unit_res[2] = 32'h40490FDB; lat[2] = 4;
    issue(2'd2, 4'd1, 32'h40490FDB, 32'h3F800000);
    wait_resp(1, 5, "post_rst");
    handshake();

`ifdef FPU_ISSUE_TIMEOUT_EN
    // unit never answers: watchdog fires 21 cycles after dval
    lat[0] = 0;
    issue(2'd0, 4'd6, 32'h1, 32'h2);
    wait_resp(1, 22, "timeout");
    handshake();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
